rob_nway: RTL and testbench
===========================

Name: rob_nway

Overview:
- Parametrised N-way reorder buffer: successor to the fixed 2-way ROB.
- Accepts up to WAYS renamed instructions per cycle in program order and tracks completion from CDB_PORTS completion buses.
- Retires up to WAYS consecutive completed entries per cycle from the head.
- Adds a branch-mispredict recovery squash that flushes all younger entries. Sits between rename/dispatch and the retire/architectural-map stage.

Parameters:
- ROB_SIZE, 64: number of entries; must be a power of 2, >= 2*WAYS.
- IDX_W, $clog2(ROB_SIZE): entry index width.
- WAYS, 2: dispatch and retire width, 1..4.
- CDB_PORTS, 2: completion ports, 1..4.
- PAYLOAD_W, 64: opaque per-entry payload (PC, T_new, T_old, flags), stored and returned unchanged.
- XLEN, 32: target PC width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- dp_valid  in  WAYS  dispatch lane valid; set bits must be contiguous from lane 0.
- dp_payload  in  WAYS*PAYLOAD_W  per-lane payload.
- dp_stall  in  1  global dispatch stall; no lane accepted.
- dp_accept  out  WAYS  lane i written this cycle.
- dp_idx  out  WAYS*IDX_W  index assigned to lane i (tail+i mod ROB_SIZE).
- cp_valid  in  CDB_PORTS  completion valid.
- cp_idx  in  CDB_PORTS*IDX_W  completing entry.
- cp_mispred  in  CDB_PORTS  branch resolved mispredicted.
- cp_target  in  CDB_PORTS*XLEN  correct target PC (meaningful when cp_mispred).
- rt_enable  in  1  retire permitted this cycle (e.g. store queue ready).
- rt_valid  out  WAYS  slot j retires this cycle.
- rt_payload  out  WAYS*PAYLOAD_W  payload of head+j.
- rt_idx  out  WAYS*IDX_W  index head+j.
- squash  out  1  mispredicted entry retiring; flush front end.
- squash_pc  out  XLEN  redirect target, valid with squash.
- head  out  IDX_W  oldest entry index.
- tail  out  IDX_W  next free index.
- entry_cnt  out  IDX_W+1  occupied entries.
- free_cnt  out  IDX_W+1  ROB_SIZE - entry_cnt.

Behaviour:
- State: per-entry valid, complete, mispred, target, payload; head; tail; entry_cnt. All pointers wrap mod ROB_SIZE.
- Reset (async, reset==0):
  - head = tail = 0, entry_cnt = 0, all valid/complete/mispred = 0.
  - Outputs: rt_valid = 0, squash = 0, squash_pc = 0, free_cnt = ROB_SIZE, dp_accept = 0, dp_idx[i] = i.
  - Reset mid-operation discards all contents immediately.
- Dispatch (combinational accept):
  - dp_accept[i] = dp_valid[i] & !dp_stall & (i < free_cnt) & !squash.
  - Partial acceptance is allowed; an unaccepted lane must be re-presented next cycle in lane 0 order.
  - On the clock edge, accepted entries are written with valid=1, complete=0, mispred=0.
  - tail advances by popcount(dp_accept).
  - free_cnt reflects the registered count only; same-cycle retirements do not free slots.
- Completion:
  - On the edge, for each cp_valid port whose entry is valid: set complete=1; mispred and target take cp_mispred and cp_target.
  - Completion to an invalid entry is ignored.
  - Different ports targeting the same index is illegal (the bench must not generate it).
- Retire (combinational, from registered state):
  - rt_valid[j] = rt_enable & valid[head+j] & complete[head+j] & all lower slots valid & no lower slot mispred.
  - Retirement stops at the first incomplete entry; a mispredicted entry is always the last slot retired in its group.
  - On the edge, retired entries are cleared to valid=0 and head advances by popcount(rt_valid).
- Squash:
  - squash = OR over retiring slots of mispred; squash_pc = target of that slot.
  - On that edge, every entry is cleared (valid=0, complete=0), tail = head = head + retired count, entry_cnt = 0.
  - Dispatch is blocked in the squash cycle. Completions arriving that cycle are dropped.
- Count:
  - entry_cnt_next = entry_cnt + accepted - retired, or 0 on squash.
  - entry_cnt never exceeds ROB_SIZE.
  - Full (free_cnt = 0): no lane accepted. Empty: rt_valid = 0.
- Simultaneous dispatch and retire is legal. With head == tail, entry_cnt disambiguates full from empty.
- Latency: dispatch to earliest retire is 2 cycles (dispatch edge, completion edge, retire in the following cycle).

Test Plan:
- Reset then idle, WAYS=2: free_cnt=64, dp_idx={1,0}, rt_valid=0. Assert reset low mid-run with 10 entries → entry_cnt=0 and head=tail=0 immediately.
- Fill: dispatch 2/cycle for 32 cycles, no completions → entry_cnt=64, dp_accept=0. Then free_cnt=1 with dp_valid=2'b11 → dp_accept=2'b01 only.
- In-order retire: dispatch idx 0..3, complete 3,1,0 out of order → next cycle rt_valid=2'b11 (idx 0,1); idx 2,3 held until 2 completes, then both retire.
- Mispredict: entries 0..5 valid, idx1 completes with mispred, target 0x1000, idx0 complete → rt_valid=2'b11, squash=1, squash_pc=0x1000. Next cycle entry_cnt=0, head=tail=2; dispatch in the squash cycle is not accepted.
- Wrap-around: run head/tail past 63→0 with continuous 2-wide dispatch/retire over 200 cycles → rt_idx sequence is monotonic mod 64, payloads match the dispatch order, entry_cnt stays constant.
- rt_enable=0 with complete entries at head → rt_valid=0 and head is unchanged; deassert dp_stall while full → nothing is accepted.

Source files
------------

// File: rtl/rob_nway.sv
// rtl/rob_nway.sv - N-way reorder buffer with in-order retire and mispredict squash
module rob_nway #(
    parameter int ROB_SIZE  = 64,
    parameter int IDX_W     = $clog2(ROB_SIZE),
    parameter int WAYS      = 2,
    parameter int CDB_PORTS = 2,
    parameter int PAYLOAD_W = 64,
    parameter int XLEN      = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [WAYS-1:0]               dp_valid,
    input  logic [WAYS*PAYLOAD_W-1:0]     dp_payload,
    input  logic                          dp_stall,
    output logic [WAYS-1:0]               dp_accept,
    output logic [WAYS*IDX_W-1:0]         dp_idx,
    input  logic [CDB_PORTS-1:0]          cp_valid,
    input  logic [CDB_PORTS*IDX_W-1:0]    cp_idx,
    input  logic [CDB_PORTS-1:0]          cp_mispred,
    input  logic [CDB_PORTS*XLEN-1:0]     cp_target,
    input  logic                          rt_enable,
    output logic [WAYS-1:0]               rt_valid,
    output logic [WAYS*PAYLOAD_W-1:0]     rt_payload,
    output logic [WAYS*IDX_W-1:0]         rt_idx,
    output logic                          squash,
    output logic [XLEN-1:0]               squash_pc,
    output logic [IDX_W-1:0]              head,
    output logic [IDX_W-1:0]              tail,
    output logic [IDX_W:0]                entry_cnt,
    output logic [IDX_W:0]                free_cnt
);
    localparam logic [IDX_W:0] ONE = (IDX_W+1)'(1);

    logic [ROB_SIZE-1:0]  valid_q, complete_q, mispred_q;
    logic [ROB_SIZE-1:0]  valid_n, complete_n, mispred_n;
    logic [XLEN-1:0]      target_q  [ROB_SIZE];
    logic [PAYLOAD_W-1:0] payload_q [ROB_SIZE];
    logic [IDX_W-1:0]     head_q, tail_q;
    logic [IDX_W:0]       cnt_q;
    logic [IDX_W:0]       acc_n, ret_n;
    logic [IDX_W-1:0]     ri, ci, wi;
    logic                 stop;

    assign head      = head_q;
    assign tail      = tail_q;
    assign entry_cnt = cnt_q;
    assign free_cnt  = (IDX_W+1)'(ROB_SIZE) - cnt_q;

    // Retire walks from head and stops at the first non-retirable slot or after a mispredict.
    always_comb begin
        rt_valid   = '0;
        rt_payload = '0;
        rt_idx     = '0;
        squash     = 1'b0;
        squash_pc  = '0;
        ret_n      = '0;
        stop       = 1'b0;
        ri         = head_q;
        for (int j = 0; j < WAYS; j++) begin
            ri = head_q + IDX_W'(j);
            rt_idx[j*IDX_W +: IDX_W]         = ri;
            rt_payload[j*PAYLOAD_W +: PAYLOAD_W] = payload_q[ri];
            if (!stop && rt_enable && valid_q[ri] && complete_q[ri]) begin
                rt_valid[j] = 1'b1;
                ret_n       = ret_n + ONE;
                if (mispred_q[ri]) begin
                    squash    = 1'b1;
                    squash_pc = target_q[ri];
                    stop      = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

    always_comb begin
        dp_accept = '0;
        dp_idx    = '0;
        acc_n     = '0;
        for (int i = 0; i < WAYS; i++) begin
            dp_idx[i*IDX_W +: IDX_W] = tail_q + IDX_W'(i);
            if (reset && dp_valid[i] && !dp_stall && ((IDX_W+1)'(i) < free_cnt) && !squash) begin
                dp_accept[i] = 1'b1;
                acc_n        = acc_n + ONE;
            end
        end
    end

    // Retire clears take priority over a late completion to the same entry; squash clears everything.
    always_comb begin
        valid_n    = valid_q;
        complete_n = complete_q;
        mispred_n  = mispred_q;
        ci         = '0;
        wi         = '0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            ci = cp_idx[p*IDX_W +: IDX_W];
            if (cp_valid[p] && valid_q[ci]) begin
                complete_n[ci] = 1'b1;
                mispred_n[ci]  = cp_mispred[p];
            end
        end
        for (int i = 0; i < WAYS; i++) begin
            wi = tail_q + IDX_W'(i);
            if (dp_accept[i]) begin
                valid_n[wi]    = 1'b1;
                complete_n[wi] = 1'b0;
                mispred_n[wi]  = 1'b0;
            end
        end
        for (int j = 0; j < WAYS; j++) begin
            if (rt_valid[j]) begin
                valid_n[head_q + IDX_W'(j)]    = 1'b0;
                complete_n[head_q + IDX_W'(j)] = 1'b0;
                mispred_n[head_q + IDX_W'(j)]  = 1'b0;
            end
        end
        if (squash) begin
            valid_n    = '0;
            complete_n = '0;
            mispred_n  = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q    <= '0;
            complete_q <= '0;
            mispred_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            cnt_q      <= '0;
        end else begin
            valid_q    <= valid_n;
            complete_q <= complete_n;
            mispred_q  <= mispred_n;
            head_q     <= head_q + ret_n[IDX_W-1:0];
            if (squash) begin
                tail_q <= head_q + ret_n[IDX_W-1:0];
                cnt_q  <= '0;
            end else begin
                tail_q <= tail_q + acc_n[IDX_W-1:0];
                cnt_q  <= cnt_q + acc_n - ret_n;
            end
        end
    end

    // Data storage needs no reset: it is only observed behind the valid/complete flags.
    always_ff @(posedge clock) begin
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (cp_valid[p] && valid_q[cp_idx[p*IDX_W +: IDX_W]])
                target_q[cp_idx[p*IDX_W +: IDX_W]] <= cp_target[p*XLEN +: XLEN];
        end
        for (int i = 0; i < WAYS; i++) begin
            if (dp_accept[i])
                payload_q[tail_q + IDX_W'(i)] <= dp_payload[i*PAYLOAD_W +: PAYLOAD_W];
        end
    end
endmodule

// File: tb/tb_rob_nway.sv
// tb/tb_rob_nway.sv - directed self-checking bench for rob_nway
module tb_rob_nway;
    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [1:0]   dp_valid = '0;
    logic [127:0] dp_payload = '0;
    logic         dp_stall = 1'b0;
    logic [1:0]   dp_accept;
    logic [11:0]  dp_idx;
    logic [1:0]   cp_valid = '0;
    logic [11:0]  cp_idx = '0;
    logic [1:0]   cp_mispred = '0;
    logic [63:0]  cp_target = '0;
    logic         rt_enable = 1'b1;
    logic [1:0]   rt_valid;
    logic [127:0] rt_payload;
    logic [11:0]  rt_idx;
    logic         squash;
    logic [31:0]  squash_pc;
    logic [5:0]   head, tail;
    logic [6:0]   entry_cnt, free_cnt;

    int checks = 0;
    int errors = 0;

    rob_nway dut (
        .clock(clock), .reset(reset),
        .dp_valid(dp_valid), .dp_payload(dp_payload), .dp_stall(dp_stall),
        .dp_accept(dp_accept), .dp_idx(dp_idx),
        .cp_valid(cp_valid), .cp_idx(cp_idx), .cp_mispred(cp_mispred), .cp_target(cp_target),
        .rt_enable(rt_enable), .rt_valid(rt_valid), .rt_payload(rt_payload), .rt_idx(rt_idx),
        .squash(squash), .squash_pc(squash_pc),
        .head(head), .tail(tail), .entry_cnt(entry_cnt), .free_cnt(free_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    function automatic logic [63:0] pay(input int n);
        return {16'hC0DE, 16'(n), 32'(n) ^ 32'h5A5A_5A5A};
    endfunction

    initial begin
        // reset and idle
        do_reset();
        #1;
        chk("rst_free", 128'(free_cnt), 128'd64);
        chk("rst_dpidx", 128'(dp_idx), 128'({6'd1, 6'd0}));
        chk("rst_rtv", 128'(rt_valid), 128'd0);
        chk("rst_sq", 128'(squash), 128'd0);
        chk("rst_cnt", 128'(entry_cnt), 128'd0);

        // 10 entries, then async reset mid-run
        dp_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            dp_payload = {pay(2*k+1), pay(2*k)};
            tick();
        end
        dp_valid = 2'b00;
        #1;
        chk("mid_cnt", 128'(entry_cnt), 128'd10);
        chk("mid_tail", 128'(tail), 128'd10);
        reset = 1'b0;
        #1;
        chk("arst_cnt", 128'(entry_cnt), 128'd0);
        chk("arst_head", 128'(head), 128'd0);
        chk("arst_tail", 128'(tail), 128'd0);
        chk("arst_free", 128'(free_cnt), 128'd64);
        tick();
        reset = 1'b1;
        tick();

        // fill to full with no completions
        rt_enable = 1'b0;
        dp_valid = 2'b11;
        for (int k = 0; k < 32; k++) begin
            dp_payload = {pay(2*k+1), pay(2*k)};
            #1;
            chk("fill_acc", 128'(dp_accept), 128'd3);
            tick();
        end
        dp_stall = 1'b1;
        #1;
        chk("full_stall_acc", 128'(dp_accept), 128'd0);
        dp_stall = 1'b0;
        #1;
        chk("full_acc", 128'(dp_accept), 128'd0);
        chk("full_cnt", 128'(entry_cnt), 128'd64);
        chk("full_free", 128'(free_cnt), 128'd0);
        chk("full_head", 128'(head), 128'd0);
        chk("full_tail", 128'(tail), 128'd0);

        // complete idx0 while retire is disabled
        dp_valid = 2'b00;
        cp_valid = 2'b01;
        cp_idx = 12'd0;
        tick();
        cp_valid = 2'b00;
        #1;
        chk("rten0_rtv", 128'(rt_valid), 128'd0);
        tick();
        chk("rten0_head", 128'(head), 128'd0);

        // retire one while full: same-cycle retire does not free a slot
        rt_enable = 1'b1;
        dp_valid = 2'b11;
        dp_payload = {pay(101), pay(100)};
        #1;
        chk("ret1_rtv", 128'(rt_valid), 128'd1);
        chk("ret1_idx", 128'(rt_idx[5:0]), 128'd0);
        chk("ret1_pay", 128'(rt_payload[63:0]), 128'(pay(0)));
        chk("ret1_acc", 128'(dp_accept), 128'd0);
        tick();
        chk("free1_free", 128'(free_cnt), 128'd1);
        chk("free1_acc", 128'(dp_accept), 128'd1);
        chk("free1_idx", 128'(dp_idx[5:0]), 128'd0);
        tick();
        dp_valid = 2'b00;
        #1;
        chk("refull_cnt", 128'(entry_cnt), 128'd64);
        chk("refull_tail", 128'(tail), 128'd1);
        chk("refull_head", 128'(head), 128'd1);

        // in-order retire with out-of-order completion
        do_reset();
        dp_valid = 2'b11;
        dp_payload = {pay(201), pay(200)};
        tick();
        dp_payload = {pay(203), pay(202)};
        tick();
        dp_valid = 2'b00;
        cp_valid = 2'b11;
        cp_idx = {6'd1, 6'd3};
        #1;
        chk("io_rtv0", 128'(rt_valid), 128'd0);
        tick();
        cp_valid = 2'b01;
        cp_idx = {6'd0, 6'd0};
        #1;
        chk("io_rtv1", 128'(rt_valid), 128'd0);
        tick();
        cp_valid = 2'b00;
        #1;
        chk("io_rtv2", 128'(rt_valid), 128'd3);
        chk("io_idx2", 128'(rt_idx), 128'({6'd1, 6'd0}));
        chk("io_pay2", rt_payload, {pay(201), pay(200)});
        tick();
        chk("io_hold_rtv", 128'(rt_valid), 128'd0);
        chk("io_hold_head", 128'(head), 128'd2);
        chk("io_hold_cnt", 128'(entry_cnt), 128'd2);
        cp_valid = 2'b01;
        cp_idx = {6'd0, 6'd2};
        tick();
        cp_valid = 2'b00;
        #1;
        chk("io_rtv3", 128'(rt_valid), 128'd3);
        chk("io_idx3", 128'(rt_idx), 128'({6'd3, 6'd2}));
        chk("io_pay3", rt_payload, {pay(203), pay(202)});
        tick();
        chk("io_end_cnt", 128'(entry_cnt), 128'd0);
        chk("io_end_head", 128'(head), 128'd4);
        chk("io_end_tail", 128'(tail), 128'd4);

        // mispredict squash
        do_reset();
        dp_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            dp_payload = {pay(301 + 2*k), pay(300 + 2*k)};
            tick();
        end
        dp_valid = 2'b00;
        cp_valid = 2'b11;
        cp_idx = {6'd0, 6'd1};
        cp_mispred = 2'b01;
        cp_target = {32'h0, 32'h0000_1000};
        tick();
        cp_mispred = 2'b00;
        cp_target = '0;
        cp_valid = 2'b01;
        cp_idx = {6'd0, 6'd2};
        dp_valid = 2'b11;
        #1;
        chk("sq_rtv", 128'(rt_valid), 128'd3);
        chk("sq_sq", 128'(squash), 128'd1);
        chk("sq_pc", 128'(squash_pc), 128'h1000);
        chk("sq_acc", 128'(dp_accept), 128'd0);
        tick();
        cp_valid = 2'b00;
        dp_valid = 2'b00;
        #1;
        chk("sq_cnt", 128'(entry_cnt), 128'd0);
        chk("sq_head", 128'(head), 128'd2);
        chk("sq_tail", 128'(tail), 128'd2);
        chk("sq_sq_after", 128'(squash), 128'd0);
        chk("sq_rtv_after", 128'(rt_valid), 128'd0);
        dp_valid = 2'b01;
        #1;
        chk("sq_redisp_acc", 128'(dp_accept), 128'd1);
        chk("sq_redisp_idx", 128'(dp_idx[5:0]), 128'd2);
        tick();
        dp_valid = 2'b00;
        #1;
        chk("sq_redisp_cnt", 128'(entry_cnt), 128'd1);

        // continuous 2-wide dispatch/complete/retire across the wrap point
        do_reset();
        for (int c = 0; c < 200; c++) begin
            dp_valid = 2'b11;
            dp_payload = {pay(2*c+1), pay(2*c)};
            if (c >= 1) begin
                cp_valid = 2'b11;
                cp_idx = {6'(2*(c-1)+1), 6'(2*(c-1))};
            end else begin
                cp_valid = 2'b00;
            end
            #1;
            if (c >= 2) begin
                chk("wr_rtv", 128'(rt_valid), 128'd3);
                chk("wr_idx", 128'(rt_idx), 128'({6'(2*(c-2)+1), 6'(2*(c-2))}));
                chk("wr_pay", rt_payload, {pay(2*(c-2)+1), pay(2*(c-2))});
                chk("wr_cnt", 128'(entry_cnt), 128'd4);
            end else begin
                chk("wr_rtv_warm", 128'(rt_valid), 128'd0);
            end
            tick();
        end
        dp_valid = 2'b00;
        cp_valid = 2'b00;
        #1;
        chk("wr_end_tail", 128'(tail), 128'(6'd400 % 64));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
